// File: rtl/hazard_pkg.sv
// Shared hazard-control definitions: FSM state encodings, x0 register id,
// and RV32 opcode constants also used by the main decoder.
package hazard_pkg;

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_HALT     = 2'd2;

  localparam logic [4:0] REG_X0 = 5'd0;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

endpackage

// File: rtl/hazard_wait_timer.sv
// Memory-wait timer: loads 1 on the first miss cycle, counts each further
// un-acked wait cycle, saturates at all-ones, flags expiry at MEM_TIMEOUT.
module hazard_wait_timer #(
  parameter int MEM_TIMEOUT = 255,
  parameter int TMR_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             inc,
  output logic [TMR_W-1:0] timer,
  output logic             expire
);

  localparam logic [TMR_W-1:0] TMR_MAX = '1;
  localparam logic [TMR_W-1:0] TMR_LIM = TMR_W'(MEM_TIMEOUT);

  // load / saturating increment
  always_ff @(posedge clk) begin
    if (rst)                         timer <= '0;
    else if (load)                   timer <= TMR_W'(1);
    else if (inc && timer != TMR_MAX) timer <= timer + TMR_W'(1);
  end

  assign expire = (timer == TMR_LIM);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage RV32 pipeline.
// Priority each cycle: HALT > memory wait > load-use > taken branch.
// Optional perf counters enabled by defining HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int TMR_W       = 8,
  parameter int PERF_W      = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [4:0]        id_rs1_i,
  input  logic [4:0]        id_rs2_i,
  input  logic              id_branch_i,
  input  logic              id_reg_equal_i,
  input  logic              ex_memread_i,
  input  logic [4:0]        ex_rd_i,
  input  logic              mem_req_i,
  input  logic              mem_ack_i,
  output logic              pc_write_o,
  output logic              if_id_write_o,
  output logic              if_id_flush_o,
  output logic              id_ex_bubble_o,
  output logic              stall_all_o,
  output logic              mem_err_o,
  output logic [PERF_W-1:0] stall_cnt_o,
  output logic [PERF_W-1:0] flush_cnt_o
);

  logic [1:0]       state, nxt;
  logic             mem_miss, mem_done, lu, taken;
  logic             t_load, t_inc, t_expire, set_err, release_hz;
  logic [TMR_W-1:0] timer;

  assign mem_miss = mem_req_i & ~mem_ack_i;
  // A request dropping mid-wait is illegal; it ends the wait like an ack.
  assign mem_done = mem_ack_i | ~mem_req_i;
  assign lu       = ex_memread_i & (ex_rd_i != REG_X0) &
                    ((ex_rd_i == id_rs1_i) | (ex_rd_i == id_rs2_i));
  assign taken    = id_branch_i & id_reg_equal_i;

  hazard_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT), .TMR_W(TMR_W)) u_tmr (
    .clk    (clk_i),
    .rst    (rst_i),
    .load   (t_load),
    .inc    (t_inc),
    .timer  (timer),
    .expire (t_expire)
  );

  // next-state and strobe decode; lower-priority hazards only seen once memory is idle
  always_comb begin
    pc_write_o     = 1'b1;
    if_id_write_o  = 1'b1;
    if_id_flush_o  = 1'b0;
    id_ex_bubble_o = 1'b0;
    stall_all_o    = 1'b0;
    nxt            = state;
    t_load         = 1'b0;
    t_inc          = 1'b0;
    set_err        = 1'b0;
    release_hz     = 1'b0;
    if (rst_i) begin
      pc_write_o     = 1'b0;
      if_id_write_o  = 1'b0;
      id_ex_bubble_o = 1'b1;
    end else begin
      case (state)
        ST_HALT: begin
          stall_all_o    = 1'b1;
          pc_write_o     = 1'b0;
          if_id_write_o  = 1'b0;
          id_ex_bubble_o = 1'b1;
        end
        ST_MEM_WAIT: begin
          if (!mem_done) begin
            stall_all_o   = 1'b1;
            pc_write_o    = 1'b0;
            if_id_write_o = 1'b0;
            t_inc         = 1'b1;
            if (t_expire) begin
              nxt     = ST_HALT;
              set_err = 1'b1;
            end
          end else begin
            nxt        = ST_RUN;
            release_hz = 1'b1;
          end
        end
        default: begin
          if (mem_miss) begin
            stall_all_o   = 1'b1;
            pc_write_o    = 1'b0;
            if_id_write_o = 1'b0;
            nxt           = ST_MEM_WAIT;
            t_load        = 1'b1;
          end else begin
            release_hz = 1'b1;
          end
        end
      endcase
      if (release_hz) begin
        if (lu) begin
          pc_write_o     = 1'b0;
          if_id_write_o  = 1'b0;
          id_ex_bubble_o = 1'b1;
        end else if (taken) begin
          if_id_flush_o  = 1'b1;
        end
      end
    end
  end

  // state register and sticky timeout flag
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= ST_RUN;
      mem_err_o <= 1'b0;
    end else begin
      state <= nxt;
      if (set_err) mem_err_o <= 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // stall / flush event counters, wrap naturally
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (!pc_write_o && state != ST_HALT) stall_cnt_o <= stall_cnt_o + PERF_W'(1);
      if (if_id_flush_o)                    flush_cnt_o <= flush_cnt_o + PERF_W'(1);
    end
  end
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl (MEM_TIMEOUT=4).
// Stimulus pushes one expected strobe vector per cycle; the monitor pops and
// compares at the falling edge.
module tb_pipeline_hazard_ctrl;

  localparam int PERF_W = 32;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] rs1, rs2, rd;
  logic br, eq, mr, mreq, mack;
  logic pc_w, ifid_w, flush, bubble, stall_all, err;
  logic [PERF_W-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  // {rst, pc_w, ifid_w, flush, bubble, stall_all, err}
  logic [6:0] exp_q[$];
  string      name_q[$];

  // expected strobe patterns {pc_w, ifid_w, flush, bubble, stall_all, err}
  localparam logic [5:0] E_NORM  = 6'b110000;
  localparam logic [5:0] E_LU    = 6'b000100;
  localparam logic [5:0] E_TAKEN = 6'b111000;
  localparam logic [5:0] E_MEM   = 6'b000010;
  localparam logic [5:0] E_HALT  = 6'b000111;
  localparam logic [5:0] E_RST   = 6'b000100;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .TMR_W(8), .PERF_W(PERF_W)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .id_rs1_i       (rs1),
    .id_rs2_i       (rs2),
    .id_branch_i    (br),
    .id_reg_equal_i (eq),
    .ex_memread_i   (mr),
    .ex_rd_i        (rd),
    .mem_req_i      (mreq),
    .mem_ack_i      (mack),
    .pc_write_o     (pc_w),
    .if_id_write_o  (ifid_w),
    .if_id_flush_o  (flush),
    .id_ex_bubble_o (bubble),
    .stall_all_o    (stall_all),
    .mem_err_o      (err),
    .stall_cnt_o    (stall_cnt),
    .flush_cnt_o    (flush_cnt)
  );

  // monitor: compare strobes, and counters against a small event model
  logic [PERF_W-1:0] m_stall = '0;
  logic [PERF_W-1:0] m_flush = '0;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [6:0] e;
      string      n;
      logic [5:0] act;
      e   = exp_q.pop_front();
      n   = name_q.pop_front();
      act = {pc_w, ifid_w, flush, bubble, stall_all, err};
      checks++;
      if (act !== e[5:0]) begin
        errors++;
        $display("FAIL %s: got %b want %b (pc_w ifid_w flush bubble stall_all err)", n, act, e[5:0]);
      end
      checks++;
      if (stall_cnt !== m_stall || flush_cnt !== m_flush) begin
        errors++;
        $display("FAIL %s cnt: got stall=%0d flush=%0d want stall=%0d flush=%0d",
                 n, stall_cnt, flush_cnt, m_stall, m_flush);
      end
`ifdef HAZARD_PERF_CNT_EN
      if (e[6]) begin
        m_stall = '0;
        m_flush = '0;
      end else begin
        if (!e[5] && e[5:0] != E_HALT) m_stall = m_stall + 1'b1;
        if (e[3])                      m_flush = m_flush + 1'b1;
      end
`endif
    end
  end

  task automatic vec(input logic r, input logic [4:0] a, input logic [4:0] b,
                     input logic bb, input logic ee, input logic mrd, input logic [4:0] d,
                     input logic rq, input logic ak, input logic [5:0] e, input string n);
    @(posedge clk);
    #1;
    rst = r; rs1 = a; rs2 = b; br = bb; eq = ee; mr = mrd; rd = d; mreq = rq; mack = ak;
    exp_q.push_back({r, e});
    name_q.push_back(n);
  endtask

  initial begin
    rst = 1'b1; rs1 = '0; rs2 = '0; br = 1'b0; eq = 1'b0; mr = 1'b0; rd = '0; mreq = 1'b0; mack = 1'b0;
    //   rst rs1    rs2    br eq mr rd     rq ak  expect   name
    vec(1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, E_RST,   "reset0");
    vec(1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, E_RST,   "reset1");
    vec(0, 5'd1, 5'd2, 0, 0, 0, 5'd0, 0, 0, E_NORM,  "idle");
    vec(0, 5'd5, 5'd2, 0, 0, 1, 5'd5, 0, 0, E_LU,    "lu_rs1");
    vec(0, 5'd5, 5'd2, 0, 0, 0, 5'd5, 0, 0, E_NORM,  "lu_clear");
    vec(0, 5'd3, 5'd7, 0, 0, 1, 5'd7, 0, 0, E_LU,    "lu_rs2");
    vec(0, 5'd0, 5'd0, 0, 0, 1, 5'd0, 0, 0, E_NORM,  "lu_x0");
    vec(0, 5'd1, 5'd2, 0, 0, 1, 5'd9, 0, 0, E_NORM,  "lu_nomatch");
    vec(0, 5'd1, 5'd2, 1, 1, 0, 5'd0, 0, 0, E_TAKEN, "br_taken");
    vec(0, 5'd1, 5'd2, 1, 0, 0, 5'd0, 0, 0, E_NORM,  "br_not_taken");
    vec(0, 5'd4, 5'd2, 1, 1, 1, 5'd4, 0, 0, E_LU,    "lu_over_br");
    vec(0, 5'd4, 5'd2, 1, 1, 0, 5'd4, 0, 0, E_TAKEN, "br_after_lu");
    vec(0, 5'd1, 5'd2, 0, 0, 0, 5'd0, 1, 1, E_NORM,  "mem_zero_wait");
    // three un-acked cycles then ack; load-use held off by memory wait
    vec(0, 5'd6, 5'd2, 0, 0, 1, 5'd6, 1, 0, E_MEM,   "miss_c1");
    vec(0, 5'd1, 5'd2, 0, 0, 0, 5'd0, 1, 0, E_MEM,   "miss_c2");
    vec(0, 5'd1, 5'd2, 0, 0, 0, 5'd0, 1, 0, E_MEM,   "miss_c3");
    vec(0, 5'd1, 5'd2, 0, 0, 0, 5'd0, 1, 1, E_NORM,  "miss_ack");
    vec(0, 5'd1, 5'd2, 0, 0, 0, 5'd0, 0, 0, E_NORM,  "post_ack_run");
    // request dropped without ack ends the wait
    vec(0, 5'd1, 5'd2, 0, 0, 0, 5'd0, 1, 0, E_MEM,   "drop_c1");
    vec(0, 5'd1, 5'd2, 1, 1, 0, 5'd0, 0, 0, E_TAKEN, "drop_release");
    vec(0, 5'd1, 5'd2, 0, 0, 0, 5'd0, 0, 0, E_NORM,  "drop_run");
    // timeout: miss cycle (timer->1), waits at timer 1..4, then HALT
    vec(0, 5'd1, 5'd2, 0, 0, 0, 5'd0, 1, 0, E_MEM,   "to_c1");
    vec(0, 5'd1, 5'd2, 0, 0, 0, 5'd0, 1, 0, E_MEM,   "to_t1");
    vec(0, 5'd1, 5'd2, 0, 0, 0, 5'd0, 1, 0, E_MEM,   "to_t2");
    vec(0, 5'd1, 5'd2, 0, 0, 0, 5'd0, 1, 0, E_MEM,   "to_t3");
    vec(0, 5'd1, 5'd2, 0, 0, 0, 5'd0, 1, 0, E_MEM,   "to_t4");
    vec(0, 5'd1, 5'd2, 0, 0, 0, 5'd0, 1, 0, E_HALT,  "halt");
    vec(0, 5'd1, 5'd2, 1, 1, 0, 5'd0, 1, 1, E_HALT,  "halt_ack_ignored");
    vec(0, 5'd1, 5'd2, 0, 0, 0, 5'd0, 0, 0, E_HALT,  "halt_sticky");
    vec(1, 5'd1, 5'd2, 0, 0, 0, 5'd0, 0, 0, E_RST | 6'b000001, "halt_rst");
    vec(0, 5'd1, 5'd2, 0, 0, 0, 5'd0, 0, 0, E_NORM,  "after_halt_rst");
    // reset in the middle of a memory wait
    vec(0, 5'd1, 5'd2, 1, 1, 0, 5'd0, 1, 0, E_MEM,   "mw_c1");
    vec(0, 5'd1, 5'd2, 0, 0, 0, 5'd0, 1, 0, E_MEM,   "mw_c2");
    vec(1, 5'd1, 5'd2, 0, 0, 0, 5'd0, 1, 0, E_RST,   "mw_rst");
    vec(0, 5'd1, 5'd2, 0, 0, 0, 5'd0, 0, 0, E_NORM,  "mw_after_rst");
    // a fresh miss must again take the full timeout (timer restarted)
    vec(0, 5'd1, 5'd2, 0, 0, 0, 5'd0, 1, 0, E_MEM,   "re_c1");
    vec(0, 5'd1, 5'd2, 0, 0, 0, 5'd0, 1, 0, E_MEM,   "re_t1");
    vec(0, 5'd1, 5'd2, 0, 0, 0, 5'd0, 1, 0, E_MEM,   "re_t2");
    vec(0, 5'd1, 5'd2, 0, 0, 0, 5'd0, 1, 0, E_MEM,   "re_t3");
    vec(0, 5'd1, 5'd2, 0, 0, 0, 5'd0, 1, 1, E_NORM,  "re_ack");
    vec(0, 5'd1, 5'd2, 1, 1, 0, 5'd0, 0, 0, E_TAKEN, "final_br");

    // let the monitor drain, bounded
    begin
      int guard = 0;
      while (exp_q.size() > 0 && guard < 20) begin
        @(negedge clk);
        guard++;
      end
      #1;
      if (exp_q.size() > 0) begin
        errors++;
        $display("FAIL drain: got %0d pending want 0", exp_q.size());
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
